// File: rtl/traffic_monitor_pkg.sv
// Shared types and constants for the multi-channel AXI traffic monitor.
package traffic_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int NarrowCh = 0;
    localparam int WideCh   = 1;

endpackage

// File: rtl/traffic_monitor_chan.sv
// Per-channel counters: outstanding reads/writes, cumulative and windowed bytes,
// and a sticky protocol-error flag.
module traffic_monitor_chan
    import traffic_monitor_pkg::*;
#(
    parameter int Bytes      = 8,
    parameter int CntWidth   = 32,
    parameter int OutstWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  active,
    input  logic                  win_wrap,
    input  logic                  ar_hs,
    input  logic                  r_hs,
    input  logic                  r_last,
    input  logic                  aw_hs,
    input  logic                  w_hs,
    input  logic                  b_hs,
    output logic [OutstWidth-1:0] rd_outst,
    output logic [OutstWidth-1:0] wr_outst,
    output logic [CntWidth-1:0]   rd_bytes,
    output logic [CntWidth-1:0]   wr_bytes,
    output logic [CntWidth-1:0]   win_rd_bytes,
    output logic [CntWidth-1:0]   win_wr_bytes,
    output logic                  err
);

    localparam logic [CntWidth:0]   Beat    = (CntWidth+1)'(Bytes);
    localparam logic [OutstWidth-1:0] OneOut = OutstWidth'(1);

    logic [CntWidth-1:0] rd_acc;
    logic [CntWidth-1:0] wr_acc;
    logic rd_done, rd_inc, rd_dec, wr_inc, wr_dec;
    logic rd_ovf, rd_unf, wr_ovf, wr_unf;

    function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a, input logic add);
        logic [CntWidth:0] s;
        s = {1'b0, a} + (add ? Beat : '0);
        return s[CntWidth] ? '1 : s[CntWidth-1:0];
    endfunction

    // Simultaneous increment and decrement cancel, so neither can flag an error.
    assign rd_done = r_hs & r_last;
    assign rd_inc  = ar_hs & ~rd_done;
    assign rd_dec  = rd_done & ~ar_hs;
    assign wr_inc  = aw_hs & ~b_hs;
    assign wr_dec  = b_hs & ~aw_hs;
    assign rd_ovf  = rd_inc & (&rd_outst);
    assign rd_unf  = rd_dec & ~(|rd_outst);
    assign wr_ovf  = wr_inc & (&wr_outst);
    assign wr_unf  = wr_dec & ~(|wr_outst);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_outst     <= '0;
            wr_outst     <= '0;
            rd_bytes     <= '0;
            wr_bytes     <= '0;
            rd_acc       <= '0;
            wr_acc       <= '0;
            win_rd_bytes <= '0;
            win_wr_bytes <= '0;
            err          <= 1'b0;
        end else if (active) begin
            if (rd_inc && !rd_ovf)
                rd_outst <= rd_outst + OneOut;
            else if (rd_dec && !rd_unf)
                rd_outst <= rd_outst - OneOut;

            if (wr_inc && !wr_ovf)
                wr_outst <= wr_outst + OneOut;
            else if (wr_dec && !wr_unf)
                wr_outst <= wr_outst - OneOut;

            rd_bytes <= sat_add(rd_bytes, r_hs);
            wr_bytes <= sat_add(wr_bytes, w_hs);

            if (win_wrap) begin
                win_rd_bytes <= sat_add(rd_acc, r_hs);
                win_wr_bytes <= sat_add(wr_acc, w_hs);
                rd_acc       <= '0;
                wr_acc       <= '0;
            end else begin
                rd_acc <= sat_add(rd_acc, r_hs);
                wr_acc <= sat_add(wr_acc, w_hs);
            end

            if (rd_ovf || rd_unf || wr_ovf || wr_unf)
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/traffic_monitor_multi.sv
// Multi-channel AXI traffic monitor: run/drain sequencing, bandwidth window
// timer and drain timeout around NumCh per-channel counter blocks.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for en_i, counters frozen
//   ST_RUN   | counting traffic, waiting for end_of_sim_i
//   ST_DRAIN | counting, waiting for outstanding to reach zero or timeout
//   ST_DONE  | terminal until reset, counters frozen
module traffic_monitor_multi
    import traffic_monitor_pkg::*;
#(
    parameter int NumCh                = 2,
    parameter int BytesPerBeat [NumCh] = '{8, 64},
    parameter int CntWidth             = 32,
    parameter int OutstWidth           = 8,
    parameter int WindowCycles         = 1024,
    parameter int DrainTimeout         = 65535
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic                           end_of_sim_i,
    input  logic [NumCh-1:0]               ar_valid_i,
    input  logic [NumCh-1:0]               ar_ready_i,
    input  logic [NumCh-1:0]               aw_valid_i,
    input  logic [NumCh-1:0]               aw_ready_i,
    input  logic [NumCh-1:0]               w_valid_i,
    input  logic [NumCh-1:0]               w_ready_i,
    input  logic [NumCh-1:0]               b_valid_i,
    input  logic [NumCh-1:0]               b_ready_i,
    input  logic [NumCh-1:0]               r_valid_i,
    input  logic [NumCh-1:0]               r_ready_i,
    input  logic [NumCh-1:0]               r_last_i,
    output logic [NumCh*OutstWidth-1:0]    rd_outst_o,
    output logic [NumCh*OutstWidth-1:0]    wr_outst_o,
    output logic [NumCh*CntWidth-1:0]      rd_bytes_o,
    output logic [NumCh*CntWidth-1:0]      wr_bytes_o,
    output logic [NumCh*CntWidth-1:0]      win_rd_bytes_o,
    output logic [NumCh*CntWidth-1:0]      win_wr_bytes_o,
    output logic                           win_valid_o,
    output logic [1:0]                     state_o,
    output logic                           done_o,
    output logic                           timeout_o,
    output logic [NumCh-1:0]               err_o
);

    localparam int WinW = (WindowCycles > 1) ? $clog2(WindowCycles) : 1;
    localparam int DrW  = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;
    localparam logic [WinW-1:0] WinLast = WinW'(WindowCycles - 1);
    localparam logic [DrW-1:0]  DrLast  = DrW'(DrainTimeout - 1);

    state_t          state, state_nxt;
    logic [WinW-1:0] win_cnt;
    logic [DrW-1:0]  drain_cnt;
    logic            active, win_wrap, outst_zero, timeout_set;

    assign active     = (state == ST_RUN) || (state == ST_DRAIN);
    assign win_wrap   = active && (win_cnt == WinLast);
    assign outst_zero = ~(|{rd_outst_o, wr_outst_o});

    always_comb begin
        state_nxt   = state;
        timeout_set = 1'b0;
        case (state)
            ST_IDLE:  if (en_i) state_nxt = ST_RUN;
            ST_RUN:   if (end_of_sim_i) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                // Drained outstanding wins over an expiring timeout in the same cycle.
                if (outst_zero) begin
                    state_nxt = ST_DONE;
                end else if (drain_cnt == DrLast) begin
                    state_nxt   = ST_DONE;
                    timeout_set = 1'b1;
                end
            end
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            win_cnt     <= '0;
            drain_cnt   <= '0;
            win_valid_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            win_valid_o <= win_wrap;
            if (active)
                win_cnt <= win_wrap ? '0 : win_cnt + WinW'(1);
            if (state == ST_DRAIN)
                drain_cnt <= drain_cnt + DrW'(1);
            else
                drain_cnt <= '0;
            if (timeout_set)
                timeout_o <= 1'b1;
        end
    end

    assign state_o = state;
    assign done_o  = (state == ST_DONE);

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        traffic_monitor_chan #(
            .Bytes      (BytesPerBeat[c]),
            .CntWidth   (CntWidth),
            .OutstWidth (OutstWidth)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .active       (active),
            .win_wrap     (win_wrap),
            .ar_hs        (ar_valid_i[c] & ar_ready_i[c]),
            .r_hs         (r_valid_i[c] & r_ready_i[c]),
            .r_last       (r_last_i[c]),
            .aw_hs        (aw_valid_i[c] & aw_ready_i[c]),
            .w_hs         (w_valid_i[c] & w_ready_i[c]),
            .b_hs         (b_valid_i[c] & b_ready_i[c]),
            .rd_outst     (rd_outst_o[c*OutstWidth +: OutstWidth]),
            .wr_outst     (wr_outst_o[c*OutstWidth +: OutstWidth]),
            .rd_bytes     (rd_bytes_o[c*CntWidth +: CntWidth]),
            .wr_bytes     (wr_bytes_o[c*CntWidth +: CntWidth]),
            .win_rd_bytes (win_rd_bytes_o[c*CntWidth +: CntWidth]),
            .win_wr_bytes (win_wr_bytes_o[c*CntWidth +: CntWidth]),
            .err          (err_o[c])
        );
    end

endmodule

// File: tb/tb_traffic_monitor_multi.sv
// Directed and randomized checks of traffic_monitor_multi against a per-cycle
// behavioural model built from integer counts.
module tb_traffic_monitor_multi;

    localparam int NCH = 2;
    localparam int CW  = 12;
    localparam int OW  = 4;
    localparam int WC  = 16;
    localparam int DT  = 10;
    localparam int BPB [NCH] = '{8, 64};
    localparam int CMAX = (1 << CW) - 1;
    localparam int OMAX = (1 << OW) - 1;

    logic clk = 1'b0;
    logic rst, en, eos;
    logic [NCH-1:0] ar_valid, ar_ready, aw_valid, aw_ready, w_valid, w_ready;
    logic [NCH-1:0] b_valid, b_ready, r_valid, r_ready, r_last;
    logic [NCH*OW-1:0] rd_outst, wr_outst;
    logic [NCH*CW-1:0] rd_bytes, wr_bytes, win_rd_bytes, win_wr_bytes;
    logic              win_valid, done, timeout;
    logic [1:0]        state;
    logic [NCH-1:0]    err;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int m_state, m_wv, m_to, m_wcnt, m_drain;
    int m_rdo [NCH], m_wro [NCH], m_rdb [NCH], m_wrb [NCH];
    int m_racc [NCH], m_wacc [NCH], m_wrd [NCH], m_wwr [NCH], m_err [NCH];

    always #5 clk = ~clk;

    traffic_monitor_multi #(
        .NumCh(NCH), .BytesPerBeat(BPB), .CntWidth(CW), .OutstWidth(OW),
        .WindowCycles(WC), .DrainTimeout(DT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .end_of_sim_i(eos),
        .ar_valid_i(ar_valid), .ar_ready_i(ar_ready),
        .aw_valid_i(aw_valid), .aw_ready_i(aw_ready),
        .w_valid_i(w_valid), .w_ready_i(w_ready),
        .b_valid_i(b_valid), .b_ready_i(b_ready),
        .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
        .rd_outst_o(rd_outst), .wr_outst_o(wr_outst),
        .rd_bytes_o(rd_bytes), .wr_bytes_o(wr_bytes),
        .win_rd_bytes_o(win_rd_bytes), .win_wr_bytes_o(win_wr_bytes),
        .win_valid_o(win_valid), .state_o(state), .done_o(done),
        .timeout_o(timeout), .err_o(err)
    );

    function automatic int sat(int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic logic [NCH-1:0] rbits(int pct);
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (int'($urandom_range(0, 99)) < pct);
        return v;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit zero, wrap;
        int up, dn, rb, wb;
        if (rst) begin
            m_state = 0; m_wv = 0; m_to = 0; m_wcnt = 0; m_drain = 0;
            for (int c = 0; c < NCH; c++) begin
                m_rdo[c] = 0; m_wro[c] = 0; m_rdb[c] = 0; m_wrb[c] = 0;
                m_racc[c] = 0; m_wacc[c] = 0; m_wrd[c] = 0; m_wwr[c] = 0; m_err[c] = 0;
            end
            return;
        end
        zero = 1;
        for (int c = 0; c < NCH; c++) if (m_rdo[c] != 0 || m_wro[c] != 0) zero = 0;
        m_wv = 0;
        if (m_state == 1 || m_state == 2) begin
            wrap = (m_wcnt == WC - 1);
            for (int c = 0; c < NCH; c++) begin
                up = (ar_valid[c] && ar_ready[c]) ? 1 : 0;
                dn = (r_valid[c] && r_ready[c] && r_last[c]) ? 1 : 0;
                if (up > dn) begin if (m_rdo[c] == OMAX) m_err[c] = 1; else m_rdo[c]++; end
                else if (dn > up) begin if (m_rdo[c] == 0) m_err[c] = 1; else m_rdo[c]--; end
                up = (aw_valid[c] && aw_ready[c]) ? 1 : 0;
                dn = (b_valid[c] && b_ready[c]) ? 1 : 0;
                if (up > dn) begin if (m_wro[c] == OMAX) m_err[c] = 1; else m_wro[c]++; end
                else if (dn > up) begin if (m_wro[c] == 0) m_err[c] = 1; else m_wro[c]--; end
                rb = (r_valid[c] && r_ready[c]) ? BPB[c] : 0;
                wb = (w_valid[c] && w_ready[c]) ? BPB[c] : 0;
                m_rdb[c]  = sat(m_rdb[c] + rb);
                m_wrb[c]  = sat(m_wrb[c] + wb);
                m_racc[c] = sat(m_racc[c] + rb);
                m_wacc[c] = sat(m_wacc[c] + wb);
                if (wrap) begin
                    m_wrd[c] = m_racc[c]; m_wwr[c] = m_wacc[c];
                    m_racc[c] = 0; m_wacc[c] = 0;
                end
            end
            m_wcnt = wrap ? 0 : m_wcnt + 1;
            m_wv = wrap ? 1 : 0;
        end
        case (m_state)
            0: if (en) m_state = 1;
            1: if (eos) begin m_state = 2; m_drain = 0; end
            2: begin
                if (zero) m_state = 3;
                else begin
                    m_drain++;
                    if (m_drain == DT) begin m_state = 3; m_to = 1; end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        chk("state", 64'(state), 64'(m_state));
        chk("done", 64'(done), 64'(m_state == 3));
        chk("timeout", 64'(timeout), 64'(m_to));
        chk("win_valid", 64'(win_valid), 64'(m_wv));
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("err[%0d]", c), 64'(err[c]), 64'(m_err[c]));
            chk($sformatf("rd_outst[%0d]", c), 64'(rd_outst[c*OW +: OW]), 64'(m_rdo[c]));
            chk($sformatf("wr_outst[%0d]", c), 64'(wr_outst[c*OW +: OW]), 64'(m_wro[c]));
            chk($sformatf("rd_bytes[%0d]", c), 64'(rd_bytes[c*CW +: CW]), 64'(m_rdb[c]));
            chk($sformatf("wr_bytes[%0d]", c), 64'(wr_bytes[c*CW +: CW]), 64'(m_wrb[c]));
            chk($sformatf("win_rd[%0d]", c), 64'(win_rd_bytes[c*CW +: CW]), 64'(m_wrd[c]));
            chk($sformatf("win_wr[%0d]", c), 64'(win_wr_bytes[c*CW +: CW]), 64'(m_wwr[c]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic bus_idle();
        ar_valid = '0; ar_ready = '0; aw_valid = '0; aw_ready = '0;
        w_valid = '0; w_ready = '0; b_valid = '0; b_ready = '0;
        r_valid = '0; r_ready = '0; r_last = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; eos = 1'b0; bus_idle();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic start_drain_one_read();
        en = 1'b1; tick(); en = 1'b0;
        ar_valid = 2'b01; ar_ready = 2'b01; tick(); bus_idle();
        eos = 1'b1; tick(); eos = 1'b0;
        chk("drain_entered", 64'(state), 64'd2);
    endtask

    initial begin
        int exp035 [6] = '{1, 2, 3, 2, 1, 0};
        int n, pulses;
        bit found;

        do_reset();
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_rd_bytes", 64'(rd_bytes), 64'd0);

        // traffic while idle must not count
        for (int i = 0; i < 4; i++) begin
            ar_valid = rbits(70); ar_ready = rbits(70); w_valid = rbits(70); w_ready = rbits(70);
            r_valid = rbits(70); r_ready = rbits(70); r_last = rbits(70);
            tick();
        end
        bus_idle();
        chk("idle_no_count", 64'(wr_bytes), 64'd0);

        en = 1'b1; tick(); en = 1'b0;
        chk("run_entered", 64'(state), 64'd1);

        // three reads on ch0 then three last beats
        for (int i = 0; i < 6; i++) begin
            bus_idle();
            if (i < 3) begin ar_valid = 2'b01; ar_ready = 2'b01; end
            else begin r_valid = 2'b01; r_ready = 2'b01; r_last = 2'b01; end
            tick();
            chk("r035_outst", 64'(rd_outst[OW-1:0]), 64'(exp035[i]));
        end
        bus_idle();
        chk("r035_bytes", 64'(rd_bytes[CW-1:0]), 64'd24);

        // valid without ready counts nothing
        ar_valid = 2'b11; r_valid = 2'b11; r_last = 2'b11; w_valid = 2'b11; tick(); bus_idle();
        chk("no_ready_bytes", 64'(rd_bytes[CW-1:0]), 64'd24);

        // simultaneous AR and R-last on ch1 with two outstanding
        ar_valid = 2'b10; ar_ready = 2'b10; tick(); tick();
        r_valid = 2'b10; r_ready = 2'b10; r_last = 2'b10; tick();
        chk("r036_outst", 64'(rd_outst[OW +: OW]), 64'd2);
        chk("r036_err", 64'(err[1]), 64'd0);
        bus_idle();
        r_valid = 2'b10; r_ready = 2'b10; r_last = 2'b10; tick(); tick(); bus_idle();

        // window: align on a pulse, then four W beats on ch1
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin tick(); if (win_valid) found = 1; end
        chk("r037_sync", 64'(found), 64'd1);
        w_valid = 2'b10; w_ready = 2'b10;
        n = 0;
        for (int i = 0; i < 4; i++) begin tick(); n++; end
        bus_idle();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin tick(); n++; if (win_valid) found = 1; end
        chk("r037_period", 64'(n), 64'(WC));
        chk("r037_win_wr", 64'(win_wr_bytes[CW +: CW]), 64'd256);
        n = 0; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin tick(); n++; if (win_valid) found = 1; end
        chk("r037_period2", 64'(n), 64'(WC));
        chk("r037_empty", 64'(win_wr_bytes[CW +: CW]), 64'd0);

        // B with nothing outstanding
        b_valid = 2'b01; b_ready = 2'b01; tick(); bus_idle();
        chk("r038_outst", 64'(wr_outst[OW-1:0]), 64'd0);
        chk("r038_err", 64'(err[0]), 64'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("r038_sticky", 64'(err[0]), 64'd1);

        // randomized traffic in RUN, including saturation of narrow counters
        for (int i = 0; i < 400; i++) begin
            ar_valid = rbits(60); ar_ready = rbits(75); aw_valid = rbits(60); aw_ready = rbits(75);
            w_valid = rbits(60); w_ready = rbits(75); b_valid = rbits(40); b_ready = rbits(75);
            r_valid = rbits(60); r_ready = rbits(75); r_last = rbits(35);
            tick();
        end
        bus_idle();
        chk("sat_wide_wr", 64'(wr_bytes[CW +: CW]), 64'(CMAX));

        // drain timeout
        do_reset();
        start_drain_one_read();
        n = 0;
        while (state != 2'd3 && n < 30) begin tick(); n++; end
        chk("r039_cycles", 64'(n), 64'(DT));
        chk("r039_timeout", 64'(timeout), 64'd1);
        chk("r039_done", 64'(done), 64'd1);

        // drain completes via R-last in the fifth drain cycle
        do_reset();
        start_drain_one_read();
        for (int i = 0; i < 4; i++) tick();
        r_valid = 2'b01; r_ready = 2'b01; r_last = 2'b01; tick(); bus_idle();
        tick();
        chk("r039b_state", 64'(state), 64'd3);
        chk("r039b_timeout", 64'(timeout), 64'd0);

        // DONE holds everything and never pulses the window
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            ar_valid = rbits(60); ar_ready = rbits(75); w_valid = rbits(60); w_ready = rbits(75);
            r_valid = rbits(60); r_ready = rbits(75); r_last = rbits(50); b_valid = rbits(50); b_ready = rbits(75);
            en = 1'b1; eos = 1'b1;
            tick();
            if (win_valid) pulses++;
        end
        bus_idle(); en = 1'b0; eos = 1'b0;
        chk("done_no_pulse", 64'(pulses), 64'd0);
        chk("done_rd_bytes", 64'(rd_bytes[CW-1:0]), 64'd8);

        // reset mid-drain has priority over en/eos
        do_reset();
        start_drain_one_read();
        tick(); tick();
        rst = 1'b1; en = 1'b1; eos = 1'b1; ar_valid = 2'b11; ar_ready = 2'b11; w_valid = 2'b11; w_ready = 2'b11;
        tick();
        chk("r040_state", 64'(state), 64'd0);
        chk("r040_outst", 64'(rd_outst), 64'd0);
        rst = 1'b0; en = 1'b0; eos = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        bus_idle();
        chk("r040_no_count", 64'(wr_bytes), 64'd0);
        chk("r040_idle", 64'(state), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/traffic_monitor_multi.md
TRAFFIC_MONITOR_MULTI -- requirements
Module: traffic_monitor_multi

Interface
REQ-001 SHALL have parameter NumCh, default 2: number of monitored AXI master ports (e.g. narrow, wide).
REQ-002 SHALL have parameter BytesPerBeat, default {8,64}: per-channel bytes added per W/R handshake, an array of NumCh entries.
REQ-003 SHALL have parameter CntWidth, default 32: width of every byte counter.
REQ-004 SHALL have parameter OutstWidth, default 8: width of every outstanding-transaction counter.
REQ-005 SHALL have parameter WindowCycles, default 1024: bandwidth window length, >=2.
REQ-006 SHALL have parameter DrainTimeout, default 65535: maximum DRAIN cycles before forced DONE.
REQ-007 SHALL have port clk_i, in, 1: sole clock; all logic is rising-edge.
REQ-008 SHALL have port rst_i, in, 1: synchronous, active-high reset.
REQ-009 SHALL have port en_i, in, 1: start monitoring.
REQ-010 SHALL have port end_of_sim_i, in, 1: traffic generators finished.
REQ-011 SHALL have ports ar/aw/w/b/r _valid_i and _ready_i, plus r_last_i, in, NumCh each: per-channel handshake taps, bit c = channel c.
REQ-012 SHALL have ports rd_outst_o and wr_outst_o, out, NumCh*OutstWidth: live outstanding reads and writes.
REQ-013 SHALL have ports rd_bytes_o and wr_bytes_o, out, NumCh*CntWidth: cumulative bytes.
REQ-014 SHALL have ports win_rd_bytes_o and win_wr_bytes_o, out, NumCh*CntWidth: bytes in the last completed window.
REQ-015 SHALL have port win_valid_o, out, 1: one-cycle pulse when the window outputs update.
REQ-016 SHALL have port state_o, out, 2: IDLE=0, RUN=1, DRAIN=2, DONE=3.
REQ-017 SHALL have ports done_o and timeout_o, out, 1: DONE reached, and DONE reached by timeout.
REQ-018 SHALL have port err_o, out, NumCh: sticky protocol error per channel.

Function
REQ-019 SHALL define a handshake as valid&ready in the same cycle; valid without ready SHALL count nothing.
REQ-020 SHALL make the FSM transitions IDLE->RUN on en_i; RUN->DRAIN on end_of_sim_i; DRAIN->DONE when all rd/wr outstanding are zero; DONE terminal until reset.
REQ-021 SHALL transition DRAIN->DONE with timeout_o=1 when DrainTimeout cycles elapse with outstanding nonzero; outstanding zero in the same cycle takes precedence (timeout_o=0).
REQ-022 SHALL update counters only in RUN and DRAIN; in IDLE and DONE all counters and outputs SHALL hold.
REQ-023 SHALL increment rd_outst on an AR handshake and decrement it on an R handshake with r_last_i; both in one cycle SHALL leave it unchanged.
REQ-024 SHALL increment wr_outst on an AW handshake and decrement it on a B handshake; both in one cycle SHALL leave it unchanged.
REQ-025 SHALL hold an outstanding counter at zero on a decrement at zero and set err_o[c]; it SHALL saturate at all-ones on increment and set err_o[c].
REQ-026 SHALL add BytesPerBeat[c] to rd_bytes and the window-read accumulator on every R handshake, and to the write equivalents on every W handshake.
REQ-027 SHALL saturate byte counters at 2^CntWidth-1, with no wrap.
REQ-028 SHALL run a window counter 0..WindowCycles-1 in RUN/DRAIN, wrapping to 0; in the wrap cycle it SHALL copy accumulator+this-cycle bytes to win_*_bytes_o, clear the accumulators, and pulse win_valid_o the next cycle.
REQ-029 SHALL register all outputs, reflecting an event one cycle after its handshake.
REQ-030 SHALL NOT generate a window pulse while in DONE; a partial window SHALL NOT be emitted.

Reset
REQ-031 SHALL on rst_i=1 at a clock edge set state IDLE, all counters, accumulators, win_*, err_o, done_o, timeout_o, and win_valid_o to 0, regardless of current state (mid-DRAIN included).
REQ-032 SHALL give rst_i priority over en_i and end_of_sim_i in the same cycle.

Structure
REQ-033 SHALL place the state enum type and channel index constants (NarrowCh=0, WideCh=1) in a shared package, traffic_monitor_pkg.
REQ-034 SHALL use one sub-module, traffic_monitor_chan, instantiated NumCh times, holding the outstanding/byte/window counters and error logic; the top SHALL hold the FSM, window timer, and timeout counter.

Verification
REQ-035 SHALL cover: en_i, then 3 AR handshakes on ch0 followed by 3 R-last handshakes -> rd_outst_o[0] goes 1,2,3,2,1,0; rd_bytes_o[0]=24.
REQ-036 SHALL cover: AR and R-last handshakes in the same cycle on ch1 with rd_outst=2 -> stays 2; err_o=0.
REQ-037 SHALL cover: WindowCycles=16, 4 W beats on ch1 within a window -> win_wr_bytes_o[1]=256, win_valid_o pulses once per 16 cycles.
REQ-038 SHALL cover: B handshake with wr_outst=0 on ch0 -> wr_outst stays 0; err_o[0]=1 and stays sticky.
REQ-039 SHALL cover: end_of_sim_i with 1 read outstanding, DrainTimeout=10, no R -> DONE after 10 cycles, timeout_o=1; repeat with R-last at cycle 5 -> DONE, timeout_o=0.
REQ-040 SHALL cover: rst_i asserted in DRAIN -> next cycle state_o=0, all outputs 0; handshakes after that while en_i=0 -> no count.
